// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad scanner with debounce and 16-bit key history.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key,
   output logic        key_valid,
   output logic [15:0] data
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

   // Repeat arithmetic rewinds the hold counter by REPEAT_RATE
   if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
      $error("keypad_scanner: REPEAT_RATE must be within 1..REPEAT_DELAY");
   end

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t          state;
   logic [3:0]      rs1;
   logic [3:0]      rs;
   logic [DW-1:0]   div;
   logic            tick;
   logic [1:0]      cidx;
   logic [3:0]      pat;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   rel;
   logic [1:0]      rsel;
   logic [3:0]      code;
   logic [3:0]      col_next;

`ifdef KEYPAD_REPEAT_EN
   localparam int HW = $clog2(REPEAT_DELAY + 1);
   logic [HW-1:0]   hold;
`endif

   // Two-stage synchronizer; idle rows read high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1 <= 4'hF;
         rs  <= 4'hF;
      end else begin
         rs1 <= row;
         rs  <= rs1;
      end
   end

   // Free-running scan tick divider
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign tick     = (div == DW'(SCAN_DIV - 1));
   assign col_next = {col[2:0], col[3]};

   // Key code lookup: lowest low row wins, column from the strobe index
   always_comb begin
      rsel = 2'd3;
      if (!pat[0]) begin
         rsel = 2'd0;
      end else if (!pat[1]) begin
         rsel = 2'd1;
      end else if (!pat[2]) begin
         rsel = 2'd2;
      end
      code = 4'h0;
      case ({rsel, cidx})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'h0;
         4'hD:    code = 4'hF;
         4'hE:    code = 4'hE;
         default: code = 4'hD;
      endcase
   end

   // Scan / debounce / hold FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         col       <= 4'b1110;
         cidx      <= 2'd0;
         pat       <= 4'hF;
         cnt       <= '0;
         rel       <= '0;
         key       <= 4'h0;
         key_valid <= 1'b0;
         data      <= 16'h0000;
`ifdef KEYPAD_REPEAT_EN
         hold      <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         unique case (state)
            SCAN: begin
               if (tick) begin
                  if (rs == 4'hF) begin
                     col  <= col_next;
                     cidx <= cidx + 2'd1;
                  end else begin
                     pat   <= rs;
                     cnt   <= '0;
                     state <= DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (cnt == CW'(DEBOUNCE_TICKS)) begin
                  key       <= code;
                  key_valid <= 1'b1;
                  data      <= {data[11:0], code};
                  rel       <= '0;
`ifdef KEYPAD_REPEAT_EN
                  hold      <= '0;
`endif
                  state     <= HELD;
               end else if (tick) begin
                  if (rs == pat) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            HELD: begin
               if (tick) begin
                  if (rs == 4'hF) begin
                     if (rel == CW'(DEBOUNCE_TICKS - 1)) begin
                        rel   <= '0;
                        col   <= col_next;
                        cidx  <= cidx + 2'd1;
                        state <= SCAN;
                     end else begin
                        rel <= rel + 1'b1;
                     end
                  end else begin
                     rel <= '0;
                  end
`ifdef KEYPAD_REPEAT_EN
                  if (rs == pat) begin
                     if (hold == HW'(REPEAT_DELAY - 1)) begin
                        hold      <= HW'(REPEAT_DELAY - REPEAT_RATE);
                        key       <= code;
                        key_valid <= 1'b1;
                        data      <= {data[11:0], code};
                     end else begin
                        hold <= hold + 1'b1;
                     end
                  end else begin
                     hold <= '0;
                  end
`endif
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed vectors for the keypad scanner.
// Models the matrix as row[r]=0 iff col[c]=0 and key (r,c) is pressed.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DT = 3;
   localparam int RD = 6;
   localparam int RR = 2;

`ifdef KEYPAD_REPEAT_EN
   localparam int          HOLD_LONG  = 8;
   localparam int          REP_PULSES = 5;
   localparam logic [15:0] REP_DATA   = 16'hBBBB;
`else
   localparam int          HOLD_LONG  = 40;
   localparam int          REP_PULSES = 1;
   localparam logic [15:0] REP_DATA   = 16'h000B;
`endif

   typedef struct {
      logic [15:0] mask;
      int          c;
      int          hold;
      logic [3:0]  k;
      logic [15:0] d;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key;
   logic        key_valid;
   logic [15:0] data;
   logic [15:0] mask = '0;
   logic        kv_prev = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          pulses = 0;
   vec_t        vt[6];

   keypad_scanner #(
      .SCAN_DIV(SD),
      .DEBOUNCE_TICKS(DT),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .row(row),
      .col(col),
      .key(key),
      .key_valid(key_valid),
      .data(data)
   );

   always #5 clk = ~clk;

   // Keypad matrix model
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         row[r] = ~|(mask[r*4 +: 4] & ~col);
      end
   end

   // Count key_valid pulses and check each lasts one cycle
   always @(negedge clk) begin
      if (key_valid) begin
         pulses++;
         total++;
         if (kv_prev) begin
            bad++;
            $display("FAIL kv_width: key_valid high two cycles, want 1");
         end
      end
      kv_prev = key_valid;
   end

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick_wait(input int n);
      repeat (n * SD) @(negedge clk);
   endtask

   // Return at the first negedge after column c becomes strobed
   task automatic wait_col(input int c);
      int n;
      n = 0;
      while (col[c] === 1'b0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      while (col[c] !== 1'b0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         total++;
         bad++;
         $display("FAIL wait_col%0d: col=%b never strobed", c, col);
      end
   endtask

   task automatic wait_change(output int n);
      logic [3:0] prev;
      prev = col;
      n = 0;
      while (col === prev && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      logic [3:0] seq [4];
      int n;
      int p0;
      logic [15:0] d0;

      vt[0] = '{16'h0001, 0, 8, 4'h1, 16'h0021};
      vt[1] = '{16'h0008, 3, 8, 4'hA, 16'h021A};
      vt[2] = '{16'h1000, 0, 8, 4'h0, 16'h21A0};
      vt[3] = '{16'h8000, 3, 8, 4'hD, 16'h1A0D};
      vt[4] = '{16'h0020, 1, 8, 4'h5, 16'hA0D5};
      vt[5] = '{16'h4040, 2, 8, 4'h6, 16'h0D56};
      seq[0] = 4'b1101;
      seq[1] = 4'b1011;
      seq[2] = 4'b0111;
      seq[3] = 4'b1110;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_col", 16'(col), 16'h000E);
      chk("rst_key", 16'(key), 16'h0);
      chk("rst_kv", 16'(key_valid), 16'h0);
      chk("rst_data", data, 16'h0);
      rst = 1'b0;

      // Idle scanning rotation and tick spacing
      for (int i = 0; i < 4; i++) begin
         wait_change(n);
         chk($sformatf("scan_col%0d", i), 16'(col), 16'(seq[i]));
         if (i > 0) chk($sformatf("scan_gap%0d", i), 16'(n), 16'(SD));
      end
      chk("idle_pulses", 16'(pulses), 16'h0);
      chk("idle_data", data, 16'h0);

      // Long press of key 2, column frozen until release debounced
      p0 = pulses;
      wait_col(1);
      mask = 16'h0002;
      tick_wait(HOLD_LONG);
      chk("held_col", 16'(col), 16'h000D);
      mask = '0;
      repeat (8) @(negedge clk);
      chk("rel_col_hold", 16'(col), 16'h000D);
      wait_change(n);
      chk("rel_col_next", 16'(col), 16'h000B);
      repeat (8) @(negedge clk);
      chk("k2_pulses", 16'(pulses - p0), 16'h1);
      chk("k2_key", 16'(key), 16'h2);
      chk("k2_data", data, 16'h0002);

      // Table of single presses and a two-row press in one column
      foreach (vt[i]) begin
         p0 = pulses;
         wait_col(vt[i].c);
         mask = vt[i].mask;
         tick_wait(vt[i].hold);
         mask = '0;
         tick_wait(10);
         chk($sformatf("v%0d_pulses", i), 16'(pulses - p0), 16'h1);
         chk($sformatf("v%0d_key", i), 16'(key), 16'(vt[i].k));
         chk($sformatf("v%0d_data", i), data, vt[i].d);
      end

      // Short glitch on key 9 is rejected, scan resumes in place
      p0 = pulses;
      d0 = data;
      wait_col(2);
      mask = 16'h0400;
      tick_wait(2);
      mask = '0;
      repeat (5) @(negedge clk);
      chk("gl_col_hold", 16'(col), 16'h000B);
      wait_change(n);
      chk("gl_col_next", 16'(col), 16'h0007);
      tick_wait(4);
      chk("gl_pulses", 16'(pulses - p0), 16'h0);
      chk("gl_data", data, d0);

      // Key 7 held while a second key in the same column is pressed
      p0 = pulses;
      wait_col(0);
      mask = 16'h0100;
      repeat (24) @(negedge clk);
      mask = 16'h0101;
      repeat (40) @(negedge clk);
      mask = 16'h0100;
      repeat (12) @(negedge clk);
      mask = '0;
      tick_wait(10);
      chk("two_pulses", 16'(pulses - p0), 16'h1);
      chk("two_key", 16'(key), 16'h7);
      chk("two_data", data, 16'hD567);

      // Reset in the middle of debouncing key 9
      p0 = pulses;
      wait_col(2);
      mask = 16'h0400;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_col", 16'(col), 16'h000E);
      chk("mid_rst_data", data, 16'h0);
      chk("mid_rst_key", 16'(key), 16'h0);
      chk("mid_rst_kv", 16'(key_valid), 16'h0);
      mask = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_pulses", 16'(pulses - p0), 16'h0);

      // Key B held 12 ticks past accept
      p0 = pulses;
      wait_col(3);
      mask = 16'h0080;
      repeat (64) @(negedge clk);
      mask = '0;
      tick_wait(10);
      chk("rep_pulses", 16'(pulses - p0), 16'(REP_PULSES));
      chk("rep_key", 16'(key), 16'hB);
      chk("rep_data", data, REP_DATA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
